exmem_pipe_stage: RTL and testbench

// - Parametrised successor to the fixed EXE/MEM register: one generic pipeline stage with valid/ready handshake
//   and a 2-entry skid buffer, so back-pressure (stall) no longer needs a combinational path to the upstream stage.
// - Sits between EXE and MEM; also reused for MEM/WB. Payload is opaque, default = packed EXE/MEM bundle.
// - Keeps the existing bubble rule: a flushed or empty stage presents all-zero payload (WriteEnable=0, MemWrite=0).

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_sat_counter.sv | 22 ++
 rtl/exmem_pipe_stage.sv | 94 +++++++++
 tb/tb_exmem_pipe_stage.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline payload bundles for the EXE/MEM and MEM/WB stage registers.
package pipe_pkg;

   typedef struct packed {
      logic [31:0] MemWriteData;
      logic [5:0]  MemControl;
      logic        MemRead;
      logic        MemWrite;
      logic [31:0] ALUResult;
      logic [4:0]  WriteRegister;
      logic        WriteEnable;
   } exmem_t;

   localparam int EXMEM_W = $bits(exmem_t);

   typedef struct packed {
      logic [31:0] ReadData;
      logic [31:0] ALUResult;
      logic [4:0]  WriteRegister;
      logic        MemToReg;
      logic        WriteEnable;
   } memwb_t;

   localparam int MEMWB_W = $bits(memwb_t);

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module pipe_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             INC,
   output logic [CNT_W-1:0] COUNT
);

   logic [CNT_W-1:0] countReg;

   always_ff @(posedge CLOCK) begin
      if (RESET)
         countReg <= '0;
      else if (INC && (countReg != {CNT_W{1'b1}}))
         countReg <= countReg + 1'b1;
   end

   assign COUNT = countReg;

endmodule

// File: rtl/exmem_pipe_stage.sv
// Generic valid/ready pipeline stage with a 2-entry skid buffer and bubble-zeroed payload.
// Define EXMEM_PIPE_PERF_EN to add the STALL_CYCLES / FLUSH_COUNT performance counters.
module exmem_pipe_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = EXMEM_W,
   parameter int CNT_W  = 16
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              FLUSH,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [DATA_W-1:0] IN_DATA,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [DATA_W-1:0] OUT_DATA
`ifdef EXMEM_PIPE_PERF_EN
   ,
   output logic [CNT_W-1:0]  STALL_CYCLES,
   output logic [CNT_W-1:0]  FLUSH_COUNT
`endif
);

   logic              mValidReg;
   logic [DATA_W-1:0] mDataReg;
   logic              sValidReg;
   logic [DATA_W-1:0] sDataReg;

   logic acc;
   logic mainFree;

   assign IN_READY  = !sValidReg;
   assign OUT_VALID = mValidReg;
   assign OUT_DATA  = mDataReg;

   assign acc      = IN_VALID && !sValidReg;
   assign mainFree = !mValidReg || OUT_READY;

   // Invalid entries are always stored as zero, so OUT_DATA is a bubble without extra gating.
   always_ff @(posedge CLOCK) begin
      if (RESET || FLUSH) begin
         mValidReg <= 1'b0;
         mDataReg  <= '0;
         sValidReg <= 1'b0;
         sDataReg  <= '0;
      end else if (mainFree) begin
         if (sValidReg) begin
            mValidReg <= 1'b1;
            mDataReg  <= sDataReg;
            if (acc) begin
               sDataReg <= IN_DATA;
            end else begin
               sValidReg <= 1'b0;
               sDataReg  <= '0;
            end
         end else if (acc) begin
            mValidReg <= 1'b1;
            mDataReg  <= IN_DATA;
         end else begin
            mValidReg <= 1'b0;
            mDataReg  <= '0;
         end
      end else if (acc) begin
         sValidReg <= 1'b1;
         sDataReg  <= IN_DATA;
      end
   end

   if (CNT_W < 1 || DATA_W < 1) begin : gBadParam
      $error("exmem_pipe_stage: CNT_W and DATA_W must be positive");
   end

`ifdef EXMEM_PIPE_PERF_EN
   // A flushed cycle is booked as a flush only, never as a stall.
   logic stallInc;
   assign stallInc = mValidReg && !OUT_READY && !FLUSH;

   pipe_sat_counter #(.CNT_W(CNT_W)) uStallCounter (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .INC   (stallInc),
      .COUNT (STALL_CYCLES)
   );

   pipe_sat_counter #(.CNT_W(CNT_W)) uFlushCounter (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .INC   (FLUSH),
      .COUNT (FLUSH_COUNT)
   );
`endif

endmodule

// File: tb/tb_exmem_pipe_stage.sv
// Self-checking bench for exmem_pipe_stage: directed scenarios plus random traffic vs a queue model.
module tb_exmem_pipe_stage;
   import pipe_pkg::*;

   localparam int DW   = EXMEM_W;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          CLOCK = 1'b0;
   logic          RESET = 1'b0;
   logic          FLUSH = 1'b0;
   logic          IN_VALID = 1'b0;
   logic          IN_READY;
   logic [DW-1:0] IN_DATA = '0;
   logic          OUT_VALID;
   logic          OUT_READY = 1'b0;
   logic [DW-1:0] OUT_DATA;
`ifdef EXMEM_PIPE_PERF_EN
   logic [CW-1:0] STALL_CYCLES;
   logic [CW-1:0] FLUSH_COUNT;
`endif

   exmem_pipe_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
      .CLOCK     (CLOCK),
      .RESET     (RESET),
      .FLUSH     (FLUSH),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .IN_DATA   (IN_DATA),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OUT_DATA  (OUT_DATA)
`ifdef EXMEM_PIPE_PERF_EN
      ,
      .STALL_CYCLES (STALL_CYCLES),
      .FLUSH_COUNT  (FLUSH_COUNT)
`endif
   );

   always #5 CLOCK = ~CLOCK;

   // Reference model: the stage is a FIFO of capacity two whose head is the output.
   logic [DW-1:0] modelQ[$];
   bit            modelKnown = 0;
   int            modelStall = 0;
   int            modelFlush = 0;
   int            errors = 0;
   int            checks = 0;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle at negedge, check registered outputs against the model, then advance the model.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic r,
                       input logic f, input logic rst);
      bit            expV, expR;
      logic [DW-1:0] expD;
      @(negedge CLOCK);
      IN_VALID  = v;
      IN_DATA   = d;
      OUT_READY = r;
      FLUSH     = f;
      RESET     = rst;
      expV = (modelQ.size() > 0);
      expD = expV ? modelQ[0] : '0;
      expR = (modelQ.size() < 2);
      if (modelKnown) begin
         check("OUT_VALID", DW'(OUT_VALID), DW'(expV));
         check("OUT_DATA", OUT_DATA, expD);
         check("IN_READY", DW'(IN_READY), DW'(expR));
`ifdef EXMEM_PIPE_PERF_EN
         check("STALL_CYCLES", DW'(STALL_CYCLES), DW'(modelStall));
         check("FLUSH_COUNT", DW'(FLUSH_COUNT), DW'(modelFlush));
`endif
      end
      if (rst) begin
         modelQ.delete();
         modelStall = 0;
         modelFlush = 0;
         modelKnown = 1;
      end else if (f) begin
         modelQ.delete();
         if (modelFlush < CMAX) modelFlush++;
      end else begin
         if (expV && !r && modelStall < CMAX) modelStall++;
         if (expV && r) void'(modelQ.pop_front());
         if (v && expR) modelQ.push_back(d);
      end
      @(posedge CLOCK);
      $display("step v=%0b d=%h r=%0b f=%0b rst=%0b | out_v=%0b out_d=%h in_r=%0b",
               v, d, r, f, rst, expV, expD, expR);
   endtask

   function automatic logic [DW-1:0] rnd();
      logic [95:0] w;
      w = {$urandom(), $urandom(), $urandom()};
      return w[DW-1:0];
   endfunction

   initial begin
      // Reset held two cycles while upstream keeps offering data.
      step(1, DW'(8'h55), 1, 0, 1);
      step(1, DW'(8'h55), 1, 0, 1);
      step(0, '0, 1, 0, 0);
      check("reset_out_valid", DW'(OUT_VALID), DW'(0));

      // Streaming with continuous OUT_READY.
      step(1, DW'(8'h11), 1, 0, 0);
      step(1, DW'(8'h22), 1, 0, 0);
      step(1, DW'(8'h33), 1, 0, 0);
      step(0, '0, 1, 0, 0);
      step(0, '0, 1, 0, 0);
      step(0, '0, 1, 0, 0);

      // Stall: 0xA in main, 0xB in skid, 0xC held upstream until released.
      step(1, DW'(4'hA), 0, 0, 0);
      step(1, DW'(4'hB), 0, 0, 0);
      step(1, DW'(4'hC), 0, 0, 0);
      step(1, DW'(4'hC), 0, 0, 0);
      check("stall_out_data", OUT_DATA, DW'(4'hA));
      check("stall_in_ready", DW'(IN_READY), DW'(0));
      step(1, DW'(4'hC), 1, 0, 0);
      step(0, '0, 1, 0, 0);
      step(0, '0, 1, 0, 0);
      step(0, '0, 1, 0, 0);

      // Flush while full, with a new offer in the flush cycle.
      step(1, DW'(4'hA), 0, 0, 0);
      step(1, DW'(4'hB), 0, 0, 0);
      step(1, DW'(4'hC), 0, 1, 0);
      step(0, '0, 1, 0, 0);
      check("flush_out_data", OUT_DATA, '0);
      step(0, '0, 1, 0, 0);

      // Reset wins over flush and a valid input.
      step(1, DW'(4'hA), 0, 0, 0);
      step(1, DW'(4'hD), 0, 1, 1);
      step(0, '0, 1, 0, 0);
      check("rst_flush_in_ready", DW'(IN_READY), DW'(1));

`ifdef EXMEM_PIPE_PERF_EN
      check("rst_flush_count", DW'(FLUSH_COUNT), DW'(0));
      // Long stall saturates the 4-bit stall counter; then three flush pulses.
      step(1, DW'(8'h77), 1, 0, 0);
      for (int i = 0; i < 20; i++) step(0, '0, 0, 0, 0);
      step(0, '0, 1, 0, 0);
      check("stall_saturated", DW'(STALL_CYCLES), DW'(15));
      step(0, '0, 1, 0, 1);
      for (int i = 0; i < 3; i++) begin
         step(0, '0, 1, 1, 0);
         step(0, '0, 1, 0, 0);
      end
      step(0, '0, 1, 0, 0);
      check("flush_count_3", DW'(FLUSH_COUNT), DW'(3));
`endif

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 2) != 0,
              $urandom_range(0, 40) == 0, $urandom_range(0, 120) == 0);
      end
      step(0, '0, 1, 0, 0);
      step(0, '0, 1, 0, 0);
      step(0, '0, 1, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
